// File: rtl/tomasulo_pkg.sv
// Shared types and sizing for the rename/dispatch front end of the Tomasulo core.
package tomasulo_pkg;

    localparam int RS_SIZE      = 8;
    localparam int ROB_SIZE     = RS_SIZE * 2 + 2;
    localparam int ROB_IDX_SIZE = $clog2(ROB_SIZE);
    localparam int GPR_COUNT    = 32;
    localparam int GPR_IDX_SIZE = $clog2(GPR_COUNT);

    typedef logic [6:0]              opcode_t;
    typedef logic [ROB_IDX_SIZE-1:0] rob_tag_t;
    typedef logic [GPR_IDX_SIZE-1:0] gpr_idx_t;

    // Highest architectural index is the hard-wired zero register.
    localparam gpr_idx_t XZR = gpr_idx_t'(GPR_COUNT - 1);

    localparam opcode_t OP_ADD = 7'h33;
    localparam opcode_t OP_ADDI = 7'h13;

    typedef struct packed {
        logic     valid;
        rob_tag_t tag;
    } rat_entry_t;

    typedef struct packed {
        opcode_t     op;
        logic [63:0] imm;
        gpr_idx_t    src1_reg;
        gpr_idx_t    src2_reg;
        logic        src1_pend;
        logic        src2_pend;
        rob_tag_t    src1_tag;
        rob_tag_t    src2_tag;
        rob_tag_t    dst_tag;
        logic        w_enable;
    } renamed_insn_t;

    // ROB size is not a power of two, so pointers wrap explicitly.
    function automatic rob_tag_t rob_next(input rob_tag_t t);
        return (t == rob_tag_t'(ROB_SIZE - 1)) ? '0 : t + 1'b1;
    endfunction

endpackage

// File: rtl/rename_rat.sv
// Register alias table: two read ports with commit-clear forwarding,
// one allocate port and one commit-clear port (allocate wins on conflict).
module rename_rat
    import tomasulo_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  gpr_idx_t rd1_idx_i,
    input  gpr_idx_t rd2_idx_i,
    output logic     rd1_pend_o,
    output logic     rd2_pend_o,
    output rob_tag_t rd1_tag_o,
    output rob_tag_t rd2_tag_o,
    input  logic     alloc_en_i,
    input  gpr_idx_t alloc_idx_i,
    input  rob_tag_t alloc_tag_i,
    input  logic     clr_en_i,
    input  gpr_idx_t clr_idx_i,
    input  rob_tag_t clr_tag_i
);

    rat_entry_t [GPR_COUNT-1:0] rat_q, rat_d;
    logic clr_hit;

    // A retiring entry only clears the mapping if it is still the youngest producer.
    assign clr_hit = clr_en_i && rat_q[clr_idx_i].valid && (rat_q[clr_idx_i].tag == clr_tag_i);

    // Source lookup; a same-cycle clear is forwarded so the reader sees the value as ready.
    always_comb begin
        rd1_pend_o = rat_q[rd1_idx_i].valid && (rd1_idx_i != XZR) && !(clr_hit && (clr_idx_i == rd1_idx_i));
        rd2_pend_o = rat_q[rd2_idx_i].valid && (rd2_idx_i != XZR) && !(clr_hit && (clr_idx_i == rd2_idx_i));
        rd1_tag_o  = rd1_pend_o ? rat_q[rd1_idx_i].tag : '0;
        rd2_tag_o  = rd2_pend_o ? rat_q[rd2_idx_i].tag : '0;
    end

    // Next table: clear first, then allocate so a new mapping overrides the clear.
    always_comb begin
        rat_d = rat_q;
        if (clr_hit) begin
            rat_d[clr_idx_i] = '0;
        end
        if (alloc_en_i) begin
            rat_d[alloc_idx_i].valid = 1'b1;
            rat_d[alloc_idx_i].tag   = alloc_tag_i;
        end
    end

    // Table register; flush and reset drop every mapping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rat_q <= '0;
        end else begin
            rat_q <= rat_d;
        end
    end

endmodule

// File: rtl/rename_dispatch.sv
// Rename/dispatch stage: allocates ROB tags in circular order, renames sources
// through the RAT, and presents the result on a registered valid/ready output.
module rename_dispatch
    import tomasulo_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  opcode_t                 in_op,
    input  logic [GPR_IDX_SIZE-1:0] in_src1,
    input  logic [GPR_IDX_SIZE-1:0] in_src2,
    input  logic [GPR_IDX_SIZE-1:0] in_dst,
    input  logic                    in_w_enable,
    input  logic [63:0]             in_imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output opcode_t                 out_op,
    output logic [63:0]             out_imm,
    output logic [GPR_IDX_SIZE-1:0] out_src1_reg,
    output logic [GPR_IDX_SIZE-1:0] out_src2_reg,
    output logic                    out_src1_pend,
    output logic                    out_src2_pend,
    output logic [ROB_IDX_SIZE-1:0] out_src1_tag,
    output logic [ROB_IDX_SIZE-1:0] out_src2_tag,
    output logic [ROB_IDX_SIZE-1:0] out_dst_tag,
    output logic                    out_w_enable,
    input  logic                    commit_valid,
    input  logic [GPR_IDX_SIZE-1:0] commit_dst,
    input  logic                    commit_w_enable,
    input  logic                    flush,
    output logic [ROB_IDX_SIZE:0]   occupancy
);

    rob_tag_t              head_q, head_d, tail_q, tail_d;
    logic [ROB_IDX_SIZE:0] occ_q, occ_d;
    renamed_insn_t         out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  accept, commit_fire;
    logic                  s1_pend, s2_pend;
    rob_tag_t              s1_tag, s2_tag;

    // Full ROB blocks intake; a commit in the same cycle frees space only next cycle.
    assign in_ready    = !flush && (!out_valid_q || out_ready) && (occ_q < (ROB_IDX_SIZE+1)'(ROB_SIZE));
    assign accept      = in_valid && in_ready;
    assign commit_fire = commit_valid && (occ_q != '0) && !flush;

    rename_rat u_rat (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .rd1_idx_i   (in_src1),
        .rd2_idx_i   (in_src2),
        .rd1_pend_o  (s1_pend),
        .rd2_pend_o  (s2_pend),
        .rd1_tag_o   (s1_tag),
        .rd2_tag_o   (s2_tag),
        .alloc_en_i  (accept && in_w_enable && (in_dst != XZR)),
        .alloc_idx_i (in_dst),
        .alloc_tag_i (tail_q),
        .clr_en_i    (commit_fire && commit_w_enable),
        .clr_idx_i   (commit_dst),
        .clr_tag_i   (head_q)
    );

    // Pointer, occupancy and output-stage next state; flush dominates everything.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            occ_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (accept) begin
                tail_d         = rob_next(tail_q);
                out_valid_d    = 1'b1;
                out_d.op       = in_op;
                out_d.imm      = in_imm;
                out_d.src1_reg = in_src1;
                out_d.src2_reg = in_src2;
                out_d.src1_pend = s1_pend;
                out_d.src2_pend = s2_pend;
                out_d.src1_tag = s1_tag;
                out_d.src2_tag = s2_tag;
                out_d.dst_tag  = tail_q;
                out_d.w_enable = in_w_enable;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            if (commit_fire) begin
                head_d = rob_next(head_q);
            end
            case ({accept, commit_fire})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // State registers; reset additionally zeroes the output payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_op        = out_q.op;
    assign out_imm       = out_q.imm;
    assign out_src1_reg  = out_q.src1_reg;
    assign out_src2_reg  = out_q.src2_reg;
    assign out_src1_pend = out_q.src1_pend;
    assign out_src2_pend = out_q.src2_pend;
    assign out_src1_tag  = out_q.src1_tag;
    assign out_src2_tag  = out_q.src2_tag;
    assign out_dst_tag   = out_q.dst_tag;
    assign out_w_enable  = out_q.w_enable;
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_rename_dispatch.sv
// Bench for rename_dispatch: directed scenarios followed by random traffic,
// every cycle compared against an array-based reference model.
module tb_rename_dispatch;
    import tomasulo_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_w_enable, out_valid, out_ready;
    logic [6:0]  in_op, out_op;
    logic [4:0]  in_src1, in_src2, in_dst, out_src1_reg, out_src2_reg, commit_dst;
    logic [63:0] in_imm, out_imm;
    logic        out_src1_pend, out_src2_pend, out_w_enable;
    logic [4:0]  out_src1_tag, out_src2_tag, out_dst_tag;
    logic        commit_valid, commit_w_enable, flush;
    logic [5:0]  occupancy;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit          m_rat_v [32];
    int          m_rat_t [32];
    int          m_rob_dst [ROB_SIZE];
    bit          m_rob_we [ROB_SIZE];
    int          m_head, m_tail, m_occ;
    bit          e_valid, e_p1, e_p2, e_we;
    int          e_op, e_s1, e_s2, e_t1, e_t2, e_dt;
    logic [63:0] e_imm;

    always #5 clk = ~clk;

    rename_dispatch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
        .in_w_enable(in_w_enable), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_op(out_op), .out_imm(out_imm),
        .out_src1_reg(out_src1_reg), .out_src2_reg(out_src2_reg),
        .out_src1_pend(out_src1_pend), .out_src2_pend(out_src2_pend),
        .out_src1_tag(out_src1_tag), .out_src2_tag(out_src2_tag),
        .out_dst_tag(out_dst_tag), .out_w_enable(out_w_enable),
        .commit_valid(commit_valid), .commit_dst(commit_dst),
        .commit_w_enable(commit_w_enable), .flush(flush), .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < 32; i++) begin
            m_rat_v[i] = 0;
            m_rat_t[i] = 0;
        end
        m_head = 0;
        m_tail = 0;
        m_occ  = 0;
        e_valid = 0;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic step();
        bit exp_rdy, acc, com, clr;
        #1;
        exp_rdy = !flush && (!e_valid || out_ready) && (m_occ < ROB_SIZE);
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (rst) begin
            model_clear_all();
            e_op = 0; e_imm = 0; e_s1 = 0; e_s2 = 0; e_p1 = 0; e_p2 = 0;
            e_t1 = 0; e_t2 = 0; e_dt = 0; e_we = 0;
        end else if (flush) begin
            model_clear_all();
        end else begin
            acc = in_valid && exp_rdy;
            com = commit_valid && (m_occ > 0);
            clr = com && commit_w_enable && m_rat_v[commit_dst] && (m_rat_t[commit_dst] == m_head);
            if (acc) begin
                e_p1 = (in_src1 != 31) && m_rat_v[in_src1] && !(clr && commit_dst == in_src1);
                e_p2 = (in_src2 != 31) && m_rat_v[in_src2] && !(clr && commit_dst == in_src2);
                e_t1 = e_p1 ? m_rat_t[in_src1] : 0;
                e_t2 = e_p2 ? m_rat_t[in_src2] : 0;
                e_op = in_op; e_imm = in_imm; e_s1 = in_src1; e_s2 = in_src2;
                e_we = in_w_enable; e_dt = m_tail; e_valid = 1;
            end else if (out_ready) begin
                e_valid = 0;
            end
            if (clr) m_rat_v[commit_dst] = 0;
            if (acc) begin
                if (in_w_enable && in_dst != 31) begin
                    m_rat_v[in_dst] = 1;
                    m_rat_t[in_dst] = m_tail;
                end
                m_rob_dst[m_tail] = in_dst;
                m_rob_we[m_tail]  = in_w_enable;
                m_tail = (m_tail + 1) % ROB_SIZE;
                m_occ++;
            end
            if (com) begin
                m_head = (m_head + 1) % ROB_SIZE;
                m_occ--;
            end
        end
        #1;
        chk("out_valid", out_valid, e_valid);
        chk("occupancy", occupancy, m_occ);
        chk("out_op", out_op, e_op);
        chk("out_imm", out_imm, e_imm);
        chk("out_src1_reg", out_src1_reg, e_s1);
        chk("out_src2_reg", out_src2_reg, e_s2);
        chk("out_src1_pend", out_src1_pend, e_p1);
        chk("out_src2_pend", out_src2_pend, e_p2);
        chk("out_src1_tag", out_src1_tag, e_t1);
        chk("out_src2_tag", out_src2_tag, e_t2);
        chk("out_dst_tag", out_dst_tag, e_dt);
        chk("out_w_enable", out_w_enable, e_we);
    endtask

    task automatic drv(input int s1, input int s2, input int dst, input bit we);
        in_valid = 1; in_op = OP_ADD; in_src1 = 5'(s1); in_src2 = 5'(s2);
        in_dst = 5'(dst); in_w_enable = we; in_imm = 64'(dst * 3 + 1);
        step();
        in_valid = 0;
    endtask

    // Commit the oldest in-flight entry using the model's record of what it wrote.
    task automatic set_commit(input bit v);
        commit_valid    = v;
        commit_dst      = 5'(m_rob_dst[m_head]);
        commit_w_enable = m_rob_we[m_head];
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        rst = 1; in_valid = 0; out_ready = 1; in_op = 0; in_src1 = 0; in_src2 = 0;
        in_dst = 0; in_w_enable = 0; in_imm = 0; commit_valid = 0; commit_dst = 0;
        commit_w_enable = 0; flush = 0;
        for (int i = 0; i < ROB_SIZE; i++) begin m_rob_dst[i] = 0; m_rob_we[i] = 0; end
        model_clear_all();
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_imm", out_imm, 0);

        // dependency chain
        drv(2, 31, 1, 1);
        chk("dep0_tag", out_dst_tag, 0);
        chk("dep0_p1", out_src1_pend, 0);
        drv(1, 31, 3, 1);
        chk("dep1_tag", out_dst_tag, 1);
        chk("dep1_p1", out_src1_pend, 1);
        chk("dep1_t1", out_src1_tag, 0);
        drv(1, 31, 1, 1);
        chk("dep2_tag", out_dst_tag, 2);
        chk("dep2_p1", out_src1_pend, 1);
        chk("dep2_t1", out_src1_tag, 0);
        drv(1, 31, 4, 1);
        chk("dep3_t1", out_src1_tag, 2);

        // full ROB, then wrap
        do_reset();
        for (int i = 0; i < ROB_SIZE; i++) drv(31, 31, 0, 0);
        chk("full_occ", occupancy, 18);
        in_valid = 1;
        #1 chk("full_rdy", in_ready, 0);
        step();
        set_commit(1);
        #1 chk("full_nobypass", in_ready, 0);
        step();
        commit_valid = 0;
        #1 chk("full_freed", in_ready, 1);
        step();
        in_valid = 0;
        chk("wrap_tag", out_dst_tag, 0);
        chk("wrap_occ", occupancy, 18);

        // commit/dispatch race on X5, then commit-clear forwarding on X6
        do_reset();
        drv(31, 31, 5, 1);
        drv(31, 31, 6, 1);
        drv(31, 31, 7, 1);
        set_commit(1);
        drv(31, 31, 5, 1);
        commit_valid = 0;
        chk("race_tag", out_dst_tag, 3);
        drv(5, 31, 9, 0);
        chk("race_p1", out_src1_pend, 1);
        chk("race_t1", out_src1_tag, 3);
        set_commit(1);
        drv(6, 31, 9, 0);
        commit_valid = 0;
        chk("fwd_p1", out_src1_pend, 0);

        // backpressure
        do_reset();
        out_ready = 0;
        drv(31, 31, 8, 1);
        in_valid = 1;
        for (int i = 0; i < 4; i++) step();
        chk("bp_tag", out_dst_tag, 0);
        chk("bp_occ", occupancy, 1);
        out_ready = 1;
        step();
        in_valid = 0;
        chk("bp_resume", out_dst_tag, 1);

        // zero register
        do_reset();
        drv(31, 31, 31, 1);
        chk("xzr_tag", out_dst_tag, 0);
        drv(31, 31, 2, 1);
        chk("xzr_p1", out_src1_pend, 0);
        chk("xzr_tag2", out_dst_tag, 1);

        // flush with accept and commit in the same cycle
        do_reset();
        for (int i = 0; i < 6; i++) drv(31, 31, i + 1, 1);
        chk("fl_occ6", occupancy, 6);
        flush = 1; in_valid = 1; set_commit(1);
        step();
        flush = 0; in_valid = 0; commit_valid = 0;
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", out_valid, 0);
        drv(1, 2, 3, 1);
        chk("fl_p1", out_src1_pend, 0);
        chk("fl_p2", out_src2_pend, 0);
        chk("fl_tag", out_dst_tag, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 149) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            set_commit($urandom_range(0, 9) < 4);
            in_op = 7'($urandom);
            in_src1 = 5'($urandom);
            in_src2 = 5'($urandom);
            in_dst = 5'($urandom_range(0, 7) == 0 ? 31 : $urandom_range(0, 7));
            in_w_enable = ($urandom_range(0, 3) != 0);
            in_imm = {$urandom, $urandom};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
